// File: rtl/mult_job_sequencer.sv
// Front-end job sequencer for the Booth multiplier.
// Operand pairs arrive over valid/ready and wait in a one-entry pending buffer.
// Each job is issued to the multiplier with a single start pulse. The product is
// captured into a valid/ready result register once fin is seen. A watchdog drops
// any job whose multiplier never finishes, and latches a sticky error flag.
module mult_job_sequencer #(
   parameter int WIDTH   = 3,
   parameter int TIMEOUT = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   output logic               mul_start,
   output logic [WIDTH-1:0]   mul_m,
   output logic [WIDTH-1:0]   mul_q,
   input  logic               mul_fin,
   input  logic [2*WIDTH-1:0] mul_product,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out_product,
   output logic               busy,
   output logic               err
);

   localparam int TW = $clog2(TIMEOUT) + 1;
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      HOLD  = 2'd3
   } state_t;

   state_t             state_r;
   logic               buf_valid_r;
   logic [WIDTH-1:0]   buf_a_r;
   logic [WIDTH-1:0]   buf_b_r;
   logic [TW-1:0]      timer_r;

   logic               accept_s;
   logic               take_s;
   logic               slot_free_s;
   logic               fin_seen_s;
   logic               capture_s;
   logic               timeout_s;

   // Handshake status comes straight from registers, so there is no input-to-output path.
   assign in_ready = !buf_valid_r;
   assign busy     = (state_r != IDLE) || buf_valid_r;
   assign accept_s = in_valid && !buf_valid_r;
   assign take_s   = (state_r == IDLE) && buf_valid_r;

   // Decide whether this cycle captures a product, parks in HOLD or trips the watchdog.
   always_comb begin
      slot_free_s = !out_valid || out_ready;
      fin_seen_s  = 1'b0;
      capture_s   = 1'b0;
      timeout_s   = 1'b0;
      case (state_r)
         WAIT: begin
            // The first WAIT cycle is a guard: fin may still be stale from the last job.
            fin_seen_s = mul_fin && (timer_r != {TW{1'b0}});
            capture_s  = fin_seen_s && slot_free_s;
            timeout_s  = !mul_fin && (timer_r == TIMER_LAST);
         end
         HOLD: begin
            capture_s = out_ready;
         end
         default: begin
            capture_s = 1'b0;
         end
      endcase
   end

   // Pending buffer: filled by an accepted input, emptied when the FSM issues the job.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         buf_valid_r <= 1'b0;
         buf_a_r     <= {WIDTH{1'b0}};
         buf_b_r     <= {WIDTH{1'b0}};
      end else if (accept_s) begin
         buf_valid_r <= 1'b1;
         buf_a_r     <= in_a;
         buf_b_r     <= in_b;
      end else if (take_s) begin
         buf_valid_r <= 1'b0;
      end else begin
         buf_valid_r <= buf_valid_r;
      end
   end

   // Job FSM with registered start pulse, operand outputs, watchdog timer and sticky error.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r   <= IDLE;
         mul_start <= 1'b0;
         mul_m     <= {WIDTH{1'b0}};
         mul_q     <= {WIDTH{1'b0}};
         timer_r   <= {TW{1'b0}};
         err       <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (take_s) begin
                  mul_m     <= buf_a_r;
                  mul_q     <= buf_b_r;
                  mul_start <= 1'b1;
                  state_r   <= START;
               end else begin
                  mul_start <= 1'b0;
                  state_r   <= IDLE;
               end
            end
            START: begin
               mul_start <= 1'b0;
               timer_r   <= {TW{1'b0}};
               state_r   <= WAIT;
            end
            WAIT: begin
               mul_start <= 1'b0;
               if (capture_s) begin
                  state_r <= IDLE;
               end else if (fin_seen_s) begin
                  state_r <= HOLD;
               end else if (timeout_s) begin
                  err     <= 1'b1;
                  state_r <= IDLE;
               end else begin
                  timer_r <= timer_r + TW'(1);
               end
            end
            HOLD: begin
               mul_start <= 1'b0;
               if (capture_s) begin
                  state_r <= IDLE;
               end else begin
                  state_r <= HOLD;
               end
            end
            default: begin
               mul_start <= 1'b0;
               state_r   <= IDLE;
            end
         endcase
      end
   end

   // Result register: a capture wins over a consume on the same edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid   <= 1'b0;
         out_product <= {(2*WIDTH){1'b0}};
      end else if (capture_s) begin
         out_valid   <= 1'b1;
         out_product <= mul_product;
      end else if (out_ready) begin
         out_valid   <= 1'b0;
      end else begin
         out_valid   <= out_valid;
      end
   end

endmodule

// File: tb/tb_mult_job_sequencer.sv
// Bench for mult_job_sequencer: reactive multiplier model, queue scoreboard, directed
// scenarios followed by a randomized phase with random backpressure.
module tb_mult_job_sequencer;

   localparam int W = 3;
   localparam int T = 16;

   logic           clk = 1'b0;
   logic           reset_n;
   logic           in_valid;
   logic           in_ready;
   logic [W-1:0]   in_a;
   logic [W-1:0]   in_b;
   logic           mul_start;
   logic [W-1:0]   mul_m;
   logic [W-1:0]   mul_q;
   logic           mul_fin = 1'b0;
   logic [2*W-1:0] mul_product = 6'd0;
   logic           out_valid;
   logic           out_ready;
   logic [2*W-1:0] out_product;
   logic           busy;
   logic           err;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mult_job_sequencer #(.WIDTH(W), .TIMEOUT(T)) dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .mul_start(mul_start), .mul_m(mul_m), .mul_q(mul_q),
      .mul_fin(mul_fin), .mul_product(mul_product),
      .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product),
      .busy(busy), .err(err)
   );

   // Reference product: plain signed integer multiply, truncated to the product width.
   function automatic logic [5:0] ref_mul(input logic [2:0] a, input logic [2:0] b);
      int sa;
      int sb;
      sa = $signed(a);
      sb = $signed(b);
      return 6'(sa * sb);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Multiplier model: fin drops on start (or one cycle later in lazy mode), rises after lat cycles.
   int lat_cfg = 0;
   bit lazy    = 1'b0;
   bit tie0    = 1'b0;
   logic [5:0] pend = 6'd0;
   int cnt   = 0;
   int stale = 0;

   always @(posedge clk) begin
      if (mul_start) begin
         pend  <= ref_mul(mul_m, mul_q);
         cnt   <= (lat_cfg != 0) ? lat_cfg : int'($urandom_range(1, 8));
         stale <= lazy ? 1 : 0;
         if (!lazy) mul_fin <= 1'b0;
      end else if (tie0) begin
         mul_fin <= 1'b0;
      end else if (stale > 0) begin
         stale   <= stale - 1;
         mul_fin <= 1'b0;
      end else if (cnt > 0) begin
         cnt <= cnt - 1;
         if (cnt == 1) begin
            mul_fin     <= 1'b1;
            mul_product <= pend;
         end
      end
   end

   // Scoreboard: accepts push expectations, start pulses and output transfers pop them.
   logic [5:0] exp_q[$];
   logic [5:0] op_q[$];
   bit drop_mode  = 1'b0;
   bit prev_start = 1'b0;
   int starts     = 0;

   always @(negedge clk) begin
      if (reset_n) begin
         if (in_valid && in_ready) begin
            op_q.push_back({in_a, in_b});
            if (!drop_mode) exp_q.push_back(ref_mul(in_a, in_b));
         end
         if (mul_start) begin
            starts++;
            check("start_single_cycle", 32'(prev_start), 32'd0);
            if (op_q.size() == 0) check("start_without_job", 32'd1, 32'd0);
            else check("operands", 32'({mul_m, mul_q}), 32'(op_q.pop_front()));
         end
         prev_start = mul_start;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("unexpected_output", 32'(out_product), 32'hffff);
            else check("product", 32'(out_product), 32'(exp_q.pop_front()));
         end
      end else begin
         prev_start = 1'b0;
      end
   end

   task automatic send(input logic [2:0] a, input logic [2:0] b);
      bit ok = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("send_accepted", 32'(ok), 32'd1);
   endtask

   task automatic wait_idle();
      bit ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (!busy && !out_valid) begin
            ok = 1'b1;
            break;
         end
      end
      check("idle_reached", 32'(ok), 32'd1);
   endtask

   task automatic wait_start();
      bit ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (mul_start) begin
            ok = 1'b1;
            break;
         end
      end
      check("start_seen", 32'(ok), 32'd1);
   endtask

   bit rnd_done = 1'b0;

   initial begin
      bit got;
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      in_a      = 3'd0;
      in_b      = 3'd0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_mul_start", 32'(mul_start), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_out_product", 32'(out_product), 32'd0);
      check("rst_operands", 32'({mul_m, mul_q}), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // 3 * -2 with a 7-cycle multiplier
      lat_cfg = 7;
      send(3'd3, 3'b110);
      got = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (out_valid) begin
            got = 1'b1;
            break;
         end
      end
      check("t1_out_valid", 32'(got), 32'd1);
      check("t1_product", 32'(out_product), 32'h3a);
      check("t1_one_start", 32'(starts), 32'd1);
      wait_idle();

      // back-to-back jobs, second accepted while the first is running
      lat_cfg = 0;
      send(3'd2, 3'd1);
      send(3'b100, 3'b100);
      wait_idle();
      check("t2_drained", 32'(exp_q.size()), 32'd0);

      // backpressure: result register, HOLD and buffer all occupied
      out_ready = 1'b0;
      send(3'd1, 3'd3);
      send(3'b111, 3'b010);
      send(3'b101, 3'b011);
      repeat (12) @(negedge clk);
      check("t3_in_ready_low", 32'(in_ready), 32'd0);
      check("t3_out_valid", 32'(out_valid), 32'd1);
      check("t3_busy", 32'(busy), 32'd1);
      out_ready = 1'b1;
      wait_idle();
      check("t3_drained", 32'(exp_q.size()), 32'd0);

      // watchdog: fin never rises
      tie0      = 1'b1;
      drop_mode = 1'b1;
      send(3'd1, 3'd1);
      drop_mode = 1'b0;
      wait_start();
      repeat (T) @(negedge clk);
      check("t4_err_not_early", 32'(err), 32'd0);
      @(negedge clk);
      check("t4_err_on_time", 32'(err), 32'd1);
      check("t4_no_output", 32'(out_valid), 32'd0);
      tie0 = 1'b0;
      send(3'd2, 3'd3);
      wait_idle();
      check("t4_err_sticky", 32'(err), 32'd1);
      check("t4_next_job_done", 32'(exp_q.size()), 32'd0);

      // stale fin still high in the guard cycle, holding the previous product
      lazy    = 1'b1;
      lat_cfg = 3;
      send(3'd3, 3'd3);
      wait_idle();
      check("t5_drained", 32'(exp_q.size()), 32'd0);
      lazy = 1'b0;

      // asynchronous reset in the middle of WAIT
      lat_cfg = 8;
      send(3'd1, 3'd2);
      wait_start();
      repeat (3) @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("t6_out_valid", 32'(out_valid), 32'd0);
      check("t6_mul_start", 32'(mul_start), 32'd0);
      check("t6_in_ready", 32'(in_ready), 32'd1);
      check("t6_busy", 32'(busy), 32'd0);
      check("t6_err", 32'(err), 32'd0);
      check("t6_out_product", 32'(out_product), 32'd0);
      check("t6_operands", 32'({mul_m, mul_q}), 32'd0);
      exp_q.delete();
      op_q.delete();
      @(negedge clk);
      reset_n = 1'b1;

      // randomized jobs with random backpressure and random stale-fin behaviour
      lat_cfg = 0;
      fork
         begin
            for (int j = 0; j < 40; j++) begin
               lazy = 1'($urandom_range(0, 1));
               send(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
               repeat ($urandom_range(0, 6)) @(posedge clk);
            end
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk);
               #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      out_ready = 1'b1;
      wait_idle();
      check("rnd_drained", 32'(exp_q.size()), 32'd0);
      check("rnd_ops_drained", 32'(op_q.size()), 32'd0);
      check("rnd_no_err", 32'(err), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #300000;
      bad++;
      total++;
      $display("FAIL global_time_limit: got timeout expected completion");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
